// File: rtl/parity_pkg.sv
// Shared types and mode constants for the serial parity frame codec.
// Imported by the codec top and available to anything that drives its mode pins.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR_GEN,
        PAR_CHK
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;
    localparam logic MODE_GEN  = 1'b0;
    localparam logic MODE_CHK  = 1'b1;

endpackage

// File: rtl/parity_frame_codec_if.sv
// Bit-serial valid/ready bundle for both sides of the parity codec.
// The master modport is the environment (source and sink); the slave modport is the codec.
interface parity_frame_codec_if;

    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_bit;
    logic out_last;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/parity_frame_codec.sv
// Serial parity generator/checker: forwards FRAME_LEN data bits through a single output
// register and either appends a parity bit (generator) or consumes and checks it (checker).
module parity_frame_codec
    import parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_odd,
    input  logic               mode_check,
    input  logic               err_clr,
    parity_frame_codec_if.slave bus,
    output logic               frame_done,
    output logic               frame_err,
    output logic [CNT_W-1:0]   err_count
);

    localparam int             CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME_LEN);

    state_t          state, state_next;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   cnt_next;
    logic            acc;
    logic            acc_next;
    logic            mode_odd_l;
    logic            mode_check_l;
    logic            out_valid_r;
    logic            out_bit_r;
    logic            out_last_r;

    logic            out_free;
    logic            out_fire;
    logic            in_ready;
    logic            accept;
    logic            frame_chk;
    logic            last_bit;
    logic            chk_err;
    logic            fwd;
    logic            load_par;
    logic            par_done;
    logic            chk_done;

    assign out_free = !out_valid_r || bus.out_ready;
    assign out_fire = out_valid_r && bus.out_ready;
    assign in_ready = (state != PAR_GEN) && out_free;
    assign accept   = bus.in_valid && in_ready;

    // The first bit of a frame must see the live mode pins; later bits use the latched copy.
    assign frame_chk = (state == IDLE) ? (mode_check == MODE_CHK) : (mode_check_l == MODE_CHK);
    assign cnt_next  = (state == IDLE) ? CW'(1) : bit_cnt + 1'b1;
    assign acc_next  = (state == IDLE) ? bus.in_bit : (acc ^ bus.in_bit);
    assign last_bit  = (cnt_next == LAST_CNT);
    assign chk_err   = ((acc ^ bus.in_bit) != mode_odd_l);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out_bit   = out_bit_r;
    assign bus.out_last  = out_last_r;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        fwd        = 1'b0;
        load_par   = 1'b0;
        par_done   = 1'b0;
        chk_done   = 1'b0;
        unique case (state)
            IDLE, DATA: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (last_bit) state_next = frame_chk ? PAR_CHK : PAR_GEN;
                    else          state_next = DATA;
                end
            end
            PAR_GEN: begin
                // Parity sits in the output register until the sink takes it.
                if (out_fire && out_last_r) begin
                    par_done   = 1'b1;
                    state_next = IDLE;
                end else if (out_free) begin
                    load_par = 1'b1;
                end
            end
            PAR_CHK: begin
                if (accept) begin
                    chk_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            acc          <= 1'b0;
            mode_odd_l   <= MODE_EVEN;
            mode_check_l <= MODE_GEN;
            out_valid_r  <= 1'b0;
            out_bit_r    <= 1'b0;
            out_last_r   <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            state      <= state_next;
            frame_done <= par_done || chk_done;
            frame_err  <= chk_done && chk_err;

            if (state == IDLE && accept) begin
                mode_odd_l   <= mode_odd;
                mode_check_l <= mode_check;
            end

            if (fwd) begin
                acc     <= acc_next;
                bit_cnt <= cnt_next;
            end else if (par_done || chk_done) begin
                acc     <= 1'b0;
                bit_cnt <= '0;
            end

            if (fwd) begin
                out_valid_r <= 1'b1;
                out_bit_r   <= bus.in_bit;
                out_last_r  <= last_bit && frame_chk;
            end else if (load_par) begin
                out_valid_r <= 1'b1;
                out_bit_r   <= acc ^ (mode_odd_l == MODE_ODD);
                out_last_r  <= 1'b1;
            end else if (out_fire) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end

            // A clear that lands on an error pulse still counts that error.
            if (err_clr)
                err_count <= frame_err ? CNT_W'(1) : '0;
            else if (frame_err && err_count != {CNT_W{1'b1}})
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_frame_codec.sv
// Self-checking bench for parity_frame_codec: table vectors, hand-written reset/clear
// sequences and randomized streams scored against a frame-level parity model.
module tb_parity_frame_codec;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_odd;
    logic             mode_check;
    logic             err_clr;
    logic             frame_done;
    logic             frame_err;
    logic [CNT_W-1:0] err_count;

    parity_frame_codec_if bus ();

    parity_frame_codec #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_odd   (mode_odd),
        .mode_check (mode_check),
        .err_clr    (err_clr),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef logic [0:FRAME_LEN-1] frame_t;

    typedef struct packed {
        logic b;
        logic odd;
        logic chk;
        logic first;
    } src_t;

    typedef struct packed {
        logic b;
        logic last;
    } obit_t;

    typedef struct {
        logic   odd;
        logic   chk;
        frame_t data;
        logic   par;
        logic   exp;
    } vec_t;

    src_t  src_q[$];
    obit_t exp_out[$];
    obit_t obs_out[$];
    int    exp_done[$];
    int    obs_done[$];

    int errors       = 0;
    int checks       = 0;
    int model_err    = 0;
    int pending_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Generator: the parity bit that makes the total ones count even (or odd).
    // Checker: whether data plus received parity violates the selected parity.
    function automatic logic model_exp(input logic odd, input logic chk, input frame_t data,
                                       input logic par);
        int ones;
        ones = $countones(data);
        if (!chk) return (ones % 2) != (odd ? 1 : 0);
        return ((ones + int'(par)) % 2) != (odd ? 1 : 0);
    endfunction

    function automatic void add_frame_exp(input logic odd, input logic chk, input frame_t data,
                                          input logic par, input logic exp);
        for (int i = 0; i < FRAME_LEN; i++) begin
            src_q.push_back('{b: data[i], odd: odd, chk: chk, first: (i == 0)});
            exp_out.push_back('{b: data[i], last: (chk && i == FRAME_LEN - 1)});
        end
        if (chk) begin
            src_q.push_back('{b: par, odd: odd, chk: chk, first: 1'b0});
            exp_done.push_back(int'(exp));
            if (exp) pending_errs++;
        end else begin
            exp_out.push_back('{b: exp, last: 1'b1});
            exp_done.push_back(0);
        end
    endfunction

    function automatic void add_frame(input logic odd, input logic chk, input frame_t data,
                                      input logic par);
        add_frame_exp(odd, chk, data, par, model_exp(odd, chk, data, par));
    endfunction

    // ready_mode: 0 always ready, 1 toggling, 2 random.
    task automatic run_stream(input string tag, input int ready_mode, input int valid_pct,
                              input bit clr_on_err);
        int    budget = 10 * src_q.size() + 200;
        int    drain = -1;
        int    hold_bad = 0;
        bit    hold_pend = 1'b0;
        obit_t held = '0;
        int    n;
        obs_out.delete();
        obs_done.delete();
        while (budget > 0 && drain != 0) begin
            @(negedge clk);
            budget--;
            if (hold_pend && (!bus.out_valid || bus.out_bit !== held.b || bus.out_last !== held.last))
                hold_bad++;
            if (frame_done)     obs_done.push_back(int'(frame_err));
            else if (frame_err) obs_done.push_back(2);
            err_clr = clr_on_err && frame_err;
            if (drain > 0) drain--;
            if (drain < 0 && src_q.size() == 0 && obs_out.size() >= exp_out.size() &&
                obs_done.size() >= exp_done.size())
                drain = 4;
            if (src_q.size() > 0) begin
                bus.in_valid = ($urandom_range(99) < valid_pct);
                bus.in_bit   = src_q[0].b;
                mode_odd     = src_q[0].first ? src_q[0].odd : 1'($urandom);
                mode_check   = src_q[0].first ? src_q[0].chk : 1'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (drain >= 0)           bus.out_ready = 1'b1;
            else if (ready_mode == 0) bus.out_ready = 1'b1;
            else if (ready_mode == 1) bus.out_ready = ~bus.out_ready;
            else                      bus.out_ready = 1'($urandom);
            #1;
            if (bus.in_valid && bus.in_ready) void'(src_q.pop_front());
            if (bus.out_valid && bus.out_ready) obs_out.push_back('{b: bus.out_bit, last: bus.out_last});
            hold_pend = bus.out_valid && !bus.out_ready;
            held      = '{b: bus.out_bit, last: bus.out_last};
        end
        bus.in_valid = 1'b0;
        err_clr      = 1'b0;

        check({tag, " src_consumed"}, src_q.size(), 0);
        check({tag, " out_count"}, obs_out.size(), exp_out.size());
        n = (obs_out.size() < exp_out.size()) ? obs_out.size() : exp_out.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s out[%0d] {bit,last}", tag, i), obs_out[i], exp_out[i]);
            if (obs_out[i] !== exp_out[i]) break;
        end
        check({tag, " done_count"}, obs_done.size(), exp_done.size());
        n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s frame_err[%0d]", tag, i), obs_done[i], exp_done[i]);
            if (obs_done[i] != exp_done[i]) break;
        end
        if (clr_on_err) model_err = (pending_errs > 0) ? 1 : 0;
        else repeat (pending_errs) if (model_err < CNT_MAX) model_err++;
        pending_errs = 0;
        check({tag, " err_count"}, err_count, model_err);
        check({tag, " out_hold_stable"}, hold_bad, 0);
        src_q.delete();
        exp_out.delete();
        exp_done.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{odd: 1'b0, chk: 1'b0, data: 8'b1011_0000, par: 1'b0, exp: 1'b1};
        vecs[1] = '{odd: 1'b1, chk: 1'b0, data: 8'b1100_0000, par: 1'b0, exp: 1'b1};
        vecs[2] = '{odd: 1'b0, chk: 1'b0, data: 8'b1100_0000, par: 1'b0, exp: 1'b0};
        vecs[3] = '{odd: 1'b1, chk: 1'b1, data: 8'b1000_0000, par: 1'b0, exp: 1'b0};
        vecs[4] = '{odd: 1'b1, chk: 1'b1, data: 8'b1000_0000, par: 1'b1, exp: 1'b1};
        vecs[5] = '{odd: 1'b0, chk: 1'b0, data: 8'b1111_1111, par: 1'b0, exp: 1'b0};
        vecs[6] = '{odd: 1'b1, chk: 1'b0, data: 8'b0000_0000, par: 1'b0, exp: 1'b1};
        vecs[7] = '{odd: 1'b0, chk: 1'b1, data: 8'b1111_1111, par: 1'b1, exp: 1'b1};

        rst           = 1'b1;
        err_clr       = 1'b0;
        mode_odd      = 1'b0;
        mode_check    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_bit", bus.out_bit, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_err", frame_err, 0);
        check("reset err_count", err_count, 0);
        check("reset in_ready", bus.in_ready, 1);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            add_frame_exp(vecs[v].odd, vecs[v].chk, vecs[v].data, vecs[v].par, vecs[v].exp);
            run_stream($sformatf("vec%0d", v), 0, 100, 1'b0);
        end

        // Back-to-back generator frames with no gaps on either side.
        for (int f = 0; f < 5; f++) add_frame(1'($urandom), 1'b0, frame_t'($urandom), 1'b0);
        run_stream("b2b_gen", 0, 100, 1'b0);

        // Generator under a toggling sink and random source gaps.
        for (int f = 0; f < 20; f++) add_frame(1'($urandom), 1'b0, frame_t'($urandom), 1'b0);
        run_stream("gen_toggle", 1, 60, 1'b0);

        // Mixed generator/checker frames with random parity and random backpressure.
        for (int f = 0; f < 30; f++)
            add_frame(1'($urandom), 1'($urandom), frame_t'($urandom), 1'($urandom));
        run_stream("mixed_rand", 2, 70, 1'b0);

        // Plain clear of the error counter.
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        model_err = 0;
        check("err_clr idle", err_count, 0);

        // Saturation: 260 bad checker frames.
        for (int f = 0; f < 260; f++) begin
            frame_t d;
            logic   o;
            d = frame_t'($urandom);
            o = 1'($urandom);
            add_frame(o, 1'b1, d, ~model_exp(o, 1'b0, d, 1'b0));
        end
        run_stream("saturate", 0, 100, 1'b0);
        check("saturate err_count max", err_count, CNT_MAX);

        // Clear coinciding with a frame error leaves a count of one.
        add_frame(1'b0, 1'b1, 8'b1000_0000, 1'b0);
        run_stream("clr_on_err", 0, 100, 1'b1);

        // Reset in the middle of a frame discards it.
        @(negedge clk);
        mode_odd      = 1'b0;
        mode_check    = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bit    = 1'b1;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst frame_done", frame_done, 0);
        check("midrst err_count", err_count, 0);
        model_err = 0;
        add_frame_exp(1'b0, 1'b0, 8'b1111_1111, 1'b0, 1'b0);
        run_stream("after_rst", 0, 100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
